// File: rtl/sram_dma_pkg.sv
// Shared types and sizing for the SRAM stream DMA.
// Widths here size the interface, the top and the skid FIFO.
package sram_dma_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int LEN_W      = 15;
  localparam int MEM_BYTES  = 65536;
  localparam int FIFO_DEPTH = 2;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    RESP
  } dma_state_e;
endpackage

// File: rtl/sram_stream_dma_if.sv
// Command, write/read stream, status and SRAM port bundle.
// master = the DMA, slave = everything around it.
interface sram_stream_dma_if;
  import sram_dma_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              err;
  logic [3:0]        sram_web;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    input  cmd_valid, cmd_dir, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, sram_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output done, err, sram_web, sram_addr, sram_wdata
  );

  modport slave (
    output cmd_valid, cmd_dir, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, sram_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  done, err, sram_web, sram_addr, sram_wdata
  );
endinterface

// File: rtl/dma_skid_fifo.sv
// Small circular FIFO absorbing the SRAM read latency.
// Push and pop in the same cycle are legal even when full.
module dma_skid_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] head
);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wp_q] = push_data;
      wp_d        = nxt(wp_q);
    end
    if (pop) begin
      rp_d = nxt(rp_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rp_q];
endmodule

// File: rtl/sram_stream_dma.sv
// Word DMA between valid/ready streams and a 1-cycle SRAM.
// Reads prefetch only as far as the skid FIFO can absorb.
module sram_stream_dma
  import sram_dma_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  sram_stream_dma_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef logic [ADDR_W:0] ext_t;

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              err_q, err_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              push;
  logic              pop;
  logic              issue;
  logic              reject;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] head;
  ext_t              end_addr;
  int                occ;

  dma_skid_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.sram_rdata),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  // Range check is done one bit wider so a huge length cannot wrap.
  always_comb begin
    end_addr = {1'b0, bus.cmd_addr} + (ext_t'(bus.cmd_len) << 2);
    reject   = (bus.cmd_addr[1:0] != 2'b00) ||
               (end_addr > ext_t'(MEM_BYTES));
  end

  // A word returning this cycle or already queued still owns a slot.
  always_comb begin
    push  = infl_q;
    pop   = (count != '0) && bus.rd_ready;
    occ   = int'(count) + int'(infl_q) - int'(pop);
    issue = (state_q == READ) && (occ < FIFO_DEPTH);
  end

  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    rem_d          = rem_q;
    err_d          = err_q;
    infl_d         = issue;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    bus.cmd_ready  = 1'b0;
    bus.wr_ready   = 1'b0;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    bus.sram_web   = 4'hF;
    bus.sram_addr  = addr_q;
    bus.sram_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          cur_d = bus.cmd_addr;
          rem_d = bus.cmd_len;
          err_d = reject;
          if (reject || bus.cmd_len == '0) begin
            state_d = RESP;
          end else if (bus.cmd_dir == DIR_WRITE) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_valid) begin
          bus.sram_web   = 4'h0;
          bus.sram_addr  = cur_q;
          bus.sram_wdata = bus.wr_data;
          addr_d         = cur_q;
          wdata_d        = bus.wr_data;
          cur_d          = cur_q + ADDR_W'(4);
          rem_d          = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = RESP;
          end
        end
      end
      READ: begin
        if (issue) begin
          bus.sram_addr = cur_q;
          addr_d        = cur_q;
          cur_d         = cur_q + ADDR_W'(4);
          rem_d         = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (count == '0 && !infl_q) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.done = 1'b1;
        bus.err  = err_q;
        err_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      infl_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      infl_q  <= infl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.rd_valid = (count != '0);
  assign bus.rd_data  = head;
endmodule
